demux_1para8_8bits_reg: RTL and testbench

Registered 1-to-8 demultiplexer for an 8-bit bus; the inverse of the ULA's 8:1 result-select mux. A source presents one byte plus a 3-bit destination select under a valid/ready handshake, and the byte is latched into the selected output channel. Each of the 8 channels holds one byte until its consumer acknowledges it. It sits after the ULA result path, distributing results to up to 8 destination registers or consumers.

---
 rtl/demux_1para8_8bits_reg_pkg.sv | 19 +
 rtl/demux_1para8_8bits_reg_canal.sv | 42 ++++
 rtl/demux_1para8_8bits_reg.sv | 84 ++++++++
 tb/tb_demux_1para8_8bits_reg.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_1para8_8bits_reg_pkg.sv
// Shared constants and helpers for the registered 1-to-8 byte demultiplexer.
// Channel count is fixed at 8, so the select is always 3 bits wide.
package demux_1para8_8bits_reg_pkg;

    localparam int DATA_W   = 8;
    localparam int N_CANAIS = 8;
    localparam int SEL_W    = 3;
    localparam int CNT_W    = 4;   // holds 0..N_CANAIS inclusive

    function automatic logic [CNT_W-1:0] popcount_canais(input logic [N_CANAIS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_CANAIS; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/demux_1para8_8bits_reg_canal.sv
// One output channel: a data register plus a valid flag.
// A write in the same cycle as an ack wins, so the flag stays set.
module registrador_canal_8bits
    import demux_1para8_8bits_reg_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             ack,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             v
);

    logic [WIDTH-1:0] r_q;
    logic             r_v;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
            r_v <= 1'b0;
        end else begin
            if (we) begin
                r_q <= d;
            end
            // Data is kept after an ack; only the flag drops.
            if (we) begin
                r_v <= 1'b1;
            end else if (ack) begin
                r_v <= 1'b0;
            end
        end
    end

    assign q = r_q;
    assign v = r_v;

endmodule

// File: rtl/demux_1para8_8bits_reg.sv
// Registered 1-to-8 demultiplexer: one byte per handshake is latched into the
// channel picked by sel and held there until that channel's consumer acks it.
module demux_1para8_8bits_reg
    import demux_1para8_8bits_reg_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    in,
    input  logic [SEL_W-1:0]    sel,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [WIDTH-1:0]    out0,
    output logic [WIDTH-1:0]    out1,
    output logic [WIDTH-1:0]    out2,
    output logic [WIDTH-1:0]    out3,
    output logic [WIDTH-1:0]    out4,
    output logic [WIDTH-1:0]    out5,
    output logic [WIDTH-1:0]    out6,
    output logic [WIDTH-1:0]    out7,
    output logic [N_CANAIS-1:0] out_valid,
    input  logic [N_CANAIS-1:0] out_ack,
    output logic [CNT_W-1:0]    ocupados
);

    logic [WIDTH-1:0]    w_q [N_CANAIS];
    logic [N_CANAIS-1:0] w_valid;
    logic [N_CANAIS-1:0] w_we;
    logic [N_CANAIS-1:0] w_valid_next;
    logic                w_in_ready;
    logic [CNT_W-1:0]    r_ocupados;

    // A full channel can still accept if it is being drained this same cycle.
    assign w_in_ready = ~w_valid[sel] | out_ack[sel];

    // NOTE: the default assignment before the conditional keeps this purely
    // combinational; without it, w_we would infer a latch.
    always_comb begin
        w_we = '0;
        if (in_valid && w_in_ready) begin
            w_we[sel] = 1'b1;
        end
    end

    for (genvar k = 0; k < N_CANAIS; k++) begin : g_canal
        registrador_canal_8bits #(
            .WIDTH (WIDTH)
        ) u_canal (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (w_we[k]),
            .ack   (out_ack[k]),
            .d     (in),
            .q     (w_q[k]),
            .v     (w_valid[k])
        );
    end

    // Mirrors the channel flag rule so the count lands in the same cycle as the flags.
    assign w_valid_next = w_we | (w_valid & ~out_ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ocupados <= '0;
        end else begin
            r_ocupados <= popcount_canais(w_valid_next);
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_valid;
    assign ocupados  = r_ocupados;

    assign out0 = w_q[0];
    assign out1 = w_q[1];
    assign out2 = w_q[2];
    assign out3 = w_q[3];
    assign out4 = w_q[4];
    assign out5 = w_q[5];
    assign out6 = w_q[6];
    assign out7 = w_q[7];

endmodule

// File: tb/tb_demux_1para8_8bits_reg.sv
// Self-checking bench: directed scenarios then randomized handshakes, all
// compared against a per-channel byte/flag model of the demultiplexer.
module tb_demux_1para8_8bits_reg;

    logic       clk;
    logic       rst_n;
    logic [7:0] in;
    logic [2:0] sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [7:0] out_valid;
    logic [7:0] out_ack;
    logic [3:0] ocupados;

    demux_1para8_8bits_reg dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out0      (out0),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3),
        .out4      (out4),
        .out5      (out5),
        .out6      (out6),
        .out7      (out7),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .ocupados  (ocupados)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what each channel holds and whether it is still owed.
    logic [7:0] m_data  [8];
    bit         m_full  [8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] dut_outs();
        return {out7, out6, out5, out4, out3, out2, out1, out0};
    endfunction

    function automatic logic [63:0] model_outs();
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[k*8 +: 8] = m_data[k];
        return r;
    endfunction

    function automatic logic [7:0] model_valid();
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = m_full[k];
        return r;
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int k = 0; k < 8; k++) if (m_full[k]) c++;
        return c;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 8; k++) begin
            m_data[k] = 8'h00;
            m_full[k] = 0;
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".data"},  dut_outs(),  model_outs());
        check({tag, ".valid"}, 64'(out_valid), 64'(model_valid()));
        check({tag, ".ocup"},  64'(ocupados),  64'(model_count()));
    endtask

    // One bus cycle: check registered state, present inputs, check ready,
    // then let the edge happen and advance the model.
    task automatic drive(input string tag, input logic [7:0] d, input logic [2:0] s,
                         input logic v, input logic [7:0] a);
        bit exp_ready;
        @(negedge clk);
        check_regs(tag);
        in       = d;
        sel      = s;
        in_valid = v;
        out_ack  = a;
        #1;
        exp_ready = !m_full[s] || a[s];
        check({tag, ".ready"}, 64'(in_ready), 64'(exp_ready));
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            if (v && exp_ready && k == int'(s)) begin
                m_data[k] = d;
                m_full[k] = 1;
            end else if (a[k]) begin
                m_full[k] = 0;
            end
        end
    endtask

    // Reset asserted in the high phase, checked before the next edge.
    task automatic mid_cycle_reset(input string tag);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, ".data"},  dut_outs(), 64'h0);
        check({tag, ".valid"}, 64'(out_valid), 64'h0);
        check({tag, ".ocup"},  64'(ocupados), 64'h0);
        check({tag, ".ready"}, 64'(in_ready), 64'h1);
        model_clear();
        in_valid = 1'b0;
        out_ack  = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] r_in;
        logic [2:0] r_sel;
        logic       r_v;
        bit         pend;

        rst_n    = 1'b0;
        in       = 8'h00;
        sel      = 3'd0;
        in_valid = 1'b0;
        out_ack  = 8'h00;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single write.
        drive("single", 8'hA5, 3'd3, 1'b1, 8'h00);
        @(negedge clk);
        check("single.out3", 64'(out3), 64'hA5);
        check("single.valid_c", 64'(out_valid), 64'h08);

        // Fill every channel, then try a ninth write into a full channel.
        mid_cycle_reset("rst1");
        for (int k = 0; k < 8; k++) drive("fill", 8'h10 + 8'(k), 3'(k), 1'b1, 8'h00);
        drive("stall5", 8'hEE, 3'd5, 1'b1, 8'h00);
        drive("after_stall", 8'h00, 3'd0, 1'b0, 8'h00);
        check("full.ocup_c", 64'(ocupados), 64'h8);
        check("full.out5_c", 64'(out5), 64'h15);

        // Same-channel write with ack, then drain channel 0, then cross-channel.
        drive("same_ch", 8'h99, 3'd2, 1'b1, 8'h04);
        drive("drain0", 8'h00, 3'd0, 1'b0, 8'h01);
        drive("cross", 8'h01, 3'd0, 1'b1, 8'h80);
        drive("post_cross", 8'h00, 3'd0, 1'b0, 8'h00);
        check("cross.out2_c", 64'(out2), 64'h99);
        check("cross.out7_c", 64'(out7), 64'h17);
        check("cross.valid_c", 64'(out_valid), 64'h7F);

        // Spurious ack on an empty block, then reset while channel 4 is stalled.
        mid_cycle_reset("rst2");
        drive("spurious", 8'h00, 3'd0, 1'b0, 8'hFF);
        drive("load4", 8'h44, 3'd4, 1'b1, 8'h00);
        drive("stall4", 8'h55, 3'd4, 1'b1, 8'h00);
        mid_cycle_reset("rst_stall");
        sel = 3'd4;
        #1;
        check("rst_stall.ready4", 64'(in_ready), 64'h1);

        // Randomized traffic; a stalled source keeps its byte and select.
        pend = 0;
        r_in = 8'h00; r_sel = 3'd0; r_v = 1'b0;
        for (int i = 0; i < 400; i++) begin
            logic [7:0] a;
            if (!pend) begin
                r_in  = 8'($urandom);
                r_sel = 3'($urandom);
                r_v   = ($urandom_range(0, 3) != 0);
            end
            a = 8'($urandom) & 8'($urandom);
            pend = r_v && m_full[r_sel] && !a[r_sel];
            drive("rand", r_in, r_sel, r_v, a);
        end
        drive("final", 8'h00, 3'd0, 1'b0, 8'h00);
        @(negedge clk);
        check_regs("end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
